x3q16_spimem: RTL and testbench
===============================

# x3q16_spimem

Memory controller that sits directly downstream of the x3q16 core. It turns the core's single-cycle word read/write requests into SPI mode-0 transactions on an external serial SRAM (23LC1024-class, byte addressed, 24-bit address phase). It returns read data and one-cycle `memory_ready` / `write_complete` strobes, and flags protocol overruns on `memory_critical`.

## Interface
- `CLK_DIV`, default 2: `spi_sclk` half-period in `clk` cycles; legal range 1..255.
- `clk`  input  1: system clock.
- `reset`  input  1: asynchronous, active-high reset.
- `request`  input  1: one-cycle request strobe from the core.
- `request_type`  input  1: 0 = read, 1 = write; sampled with `request`.
- `request_address`  input  16: word address; sampled with `request`.
- `data_in`  input  16: write data (core `data_out`); sampled with `request`.
- `memory_out`  output  16: read data (to core `memory_in`).
- `memory_ready`  output  1: one-cycle pulse, read data valid.
- `write_complete`  output  1: one-cycle pulse, write finished.
- `memory_critical`  output  1: one-cycle pulse, request dropped because the block was busy.
- `spi_cs_n`  output  1: chip select, active low.
- `spi_sclk`  output  1: SPI clock, idles low.
- `spi_mosi`  output  1: serial data to the SRAM.
- `spi_miso`  input  1: serial data from the SRAM.

## Operation
- Reset values: `memory_out`=0, `memory_ready`=0, `write_complete`=0, `memory_critical`=0, `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0. State is IDLE, bit counter 0, divider 0.
- States are IDLE and SHIFT.
- IDLE + `request`=1: latch type, address and `data_in`. Load a 48-bit shift frame, MSB first:
  - command byte: 0x03 for read, 0x02 for write;
  - 24-bit byte address `{7'b0, request_address, 1'b0}`;
  - 16 data bits: `data_in` for a write, zeros for a read.
  - Then drive `spi_cs_n`=0, `spi_mosi`=frame[47], `spi_sclk`=0, and go to SHIFT.
- SHIFT, per bit:
  - the divider counts CLK_DIV cycles, then `spi_sclk` rises and `spi_miso` is sampled into the receive register;
  - after CLK_DIV more cycles `spi_sclk` falls, the frame shifts left and `spi_mosi` takes the next bit.
- Read data is the last 16 sampled bits, first sampled bit = bit 15. Bits sampled during the command and address phases are discarded.
- After the 48th falling edge:
  - `spi_cs_n`=1, `spi_mosi`=0, state goes to IDLE;
  - for a read, `memory_out` is loaded and `memory_ready` pulses in the same cycle;
  - for a write, `write_complete` pulses and `memory_out` is unchanged.
- `memory_out` holds its value until the next read completes.
- `request`=1 while in SHIFT: `memory_critical` pulses for one cycle. The request is dropped and the transaction in flight is unaffected.
- `request` in the completion cycle: state is already IDLE, so the request is accepted normally. This gives a minimum `spi_cs_n` high time of 1 cycle.
- Reset mid-transaction: outputs return to reset values immediately. No completion pulse is produced, and the partial frame is abandoned.

## Timing
- Request accepted at clock edge T0: `spi_cs_n` falls at T0.
- First `spi_sclk` rise at T0+CLK_DIV.
- Bit period is 2·CLK_DIV cycles; the frame lasts 96·CLK_DIV cycles.
- `memory_ready` / `write_complete` is high for exactly the cycle starting at T0+96·CLK_DIV, coincident with `spi_cs_n` rising.
- `spi_mosi` changes only on `spi_sclk` falling edges (and at CS assert). It is stable for CLK_DIV cycles before each rising edge.
- `memory_ready` and `write_complete` are never high together. At most one completion pulse is produced per accepted request.
- The bit counter is 6 bits and terminates at 48; it never wraps within a frame.
- The divider reloads on every `spi_sclk` transition.

## Test plan
- Read word 0x0012 with CLK_DIV=2, SRAM model returning 0xBEEF -> MOSI stream 0x03, 0x000024, 0x0000; `memory_ready` high for one cycle at T0+192; `memory_out`=0xBEEF; `write_complete` stays 0.
- Write 0xA55A to word 0x8001 -> MOSI stream 0x02, 0x010002, 0xA55A; `write_complete` one cycle at T0+192; `memory_out` unchanged; model memory holds 0xA55A.
- Second `request` 10 cycles into a read -> `memory_critical` high exactly one cycle; the first read completes with correct data; no second transaction starts.
- Reset asserted at bit 20 of a write -> `spi_cs_n`=1 and `spi_sclk`=0 immediately; no `write_complete`; a read issued after reset release returns the old model contents.
- Request asserted in the `memory_ready` cycle -> accepted without `memory_critical`; `spi_cs_n` high exactly 1 cycle between frames; both reads return correct data.
- CLK_DIV=1, read -> `spi_sclk` toggles every cycle; `memory_ready` at T0+96; data correct.

Source files
------------

// File: rtl/x3q16_spimem.sv
// x3q16_spimem: turns single-cycle word read/write requests from the x3q16
// core into 48-bit SPI mode-0 frames on a 23LC1024-class serial SRAM.
// Frame = command byte, 24-bit byte address, 16 data bits, MSB first.
module x3q16_spimem #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request,
  input  logic        request_type,
  input  logic [15:0] request_address,
  input  logic [15:0] data_in,
  output logic [15:0] memory_out,
  output logic        memory_ready,
  output logic        write_complete,
  output logic        memory_critical,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] LAST_BIT = 6'd47;

  state_e      state_q, state_d;
  logic [47:0] frame_q, frame_d;
  logic [15:0] rx_q, rx_d;
  logic [5:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  div_q, div_d;
  logic        isWrite_q, isWrite_d;
  logic [15:0] memOut_q, memOut_d;
  logic        ready_q, ready_d;
  logic        wrDone_q, wrDone_d;
  logic        crit_q, crit_d;
  logic        csN_q, csN_d;
  logic        sclk_q, sclk_d;

  // Next-state logic: accept a request in IDLE, otherwise pace the SCLK
  // edges with the divider and finish the frame on the 48th falling edge.
  // MOSI is the frame MSB; after 48 shifts the frame is all zeros, so the
  // line returns low at completion without a separate register.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    rx_d      = rx_q;
    bitCnt_d  = bitCnt_q;
    div_d     = div_q;
    isWrite_d = isWrite_q;
    memOut_d  = memOut_q;
    ready_d   = 1'b0;
    wrDone_d  = 1'b0;
    crit_d    = 1'b0;
    csN_d     = csN_q;
    sclk_d    = sclk_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          isWrite_d = request_type;
          frame_d   = {(request_type ? 8'h02 : 8'h03), 7'b0, request_address, 1'b0,
                       (request_type ? data_in : 16'h0000)};
          bitCnt_d  = 6'd0;
          div_d     = 8'd0;
          csN_d     = 1'b0;
          sclk_d    = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (request) begin
          crit_d = 1'b1;
        end
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[14:0], spi_miso};
          end else begin
            sclk_d   = 1'b0;
            frame_d  = {frame_q[46:0], 1'b0};
            bitCnt_d = bitCnt_q + 6'd1;
            if (bitCnt_q == LAST_BIT) begin
              csN_d   = 1'b1;
              frame_d = 48'h0;
              state_d = IDLE;
              if (isWrite_q) begin
                wrDone_d = 1'b1;
              end else begin
                ready_d  = 1'b1;
                memOut_d = rx_q;
              end
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      frame_q   <= 48'h0;
      rx_q      <= 16'h0;
      bitCnt_q  <= 6'd0;
      div_q     <= 8'd0;
      isWrite_q <= 1'b0;
      memOut_q  <= 16'h0;
      ready_q   <= 1'b0;
      wrDone_q  <= 1'b0;
      crit_q    <= 1'b0;
      csN_q     <= 1'b1;
      sclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      rx_q      <= rx_d;
      bitCnt_q  <= bitCnt_d;
      div_q     <= div_d;
      isWrite_q <= isWrite_d;
      memOut_q  <= memOut_d;
      ready_q   <= ready_d;
      wrDone_q  <= wrDone_d;
      crit_q    <= crit_d;
      csN_q     <= csN_d;
      sclk_q    <= sclk_d;
    end
  end

  assign memory_out      = memOut_q;
  assign memory_ready    = ready_q;
  assign write_complete  = wrDone_q;
  assign memory_critical = crit_q;
  assign spi_cs_n        = csN_q;
  assign spi_sclk        = sclk_q;
  assign spi_mosi        = frame_q[47];

endmodule

// File: tb/tb_x3q16_spimem.sv
// Testbench for x3q16_spimem: a behavioural serial SRAM, a scoreboard of
// expected completions, and a second instance with CLK_DIV=1.
module tb_x3q16_spimem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        request = 1'b0;
  logic        request_type = 1'b0;
  logic [15:0] request_address = 16'h0;
  logic [15:0] data_in = 16'h0;
  logic [15:0] memory_out;
  logic        memory_ready, write_complete, memory_critical;
  logic        spi_cs_n, spi_sclk, spi_mosi;
  logic        spi_miso = 1'b0;

  logic        req1 = 1'b0;
  logic [15:0] addr1 = 16'h0;
  logic [15:0] out1;
  logic        rdy1, done1, crit1, cs1, sclk1, mosi1;
  logic        miso1 = 1'b0;

  x3q16_spimem #(.CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .request(request), .request_type(request_type),
    .request_address(request_address), .data_in(data_in), .memory_out(memory_out),
    .memory_ready(memory_ready), .write_complete(write_complete),
    .memory_critical(memory_critical), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  x3q16_spimem #(.CLK_DIV(1)) dutFast (
    .clk(clk), .reset(reset), .request(req1), .request_type(1'b0),
    .request_address(addr1), .data_in(16'h0), .memory_out(out1),
    .memory_ready(rdy1), .write_complete(done1), .memory_critical(crit1),
    .spi_cs_n(cs1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  int compareCount = 0;
  int mismatchCount = 0;
  int cycleCnt = 0;
  int critCnt = 0;
  logic [15:0] expMemOut = 16'h0;

  typedef struct {
    logic        isWrite;
    logic [47:0] frame;
    logic [15:0] data;
    int          dueCycle;
  } txn_t;
  txn_t sbQ[$];
  txn_t popped;

  task automatic checkOutput(input string tag, input logic [47:0] observed,
                             input logic [47:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Free-running cycle counter used for completion timing.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Serial SRAM model for the CLK_DIV=2 instance: captures MOSI on rising
  // SCLK, drives read data on falling SCLK, commits writes when CS rises.
  logic [15:0] mem0 [int];
  logic [47:0] cap0 = 48'h0;
  logic [7:0]  cmd0 = 8'h0;
  logic [23:0] addr0 = 24'h0;
  logic [15:0] rdWord0 = 16'h0;
  int          bits0 = 0;
  logic        cs0Prev = 1'b1, sclk0Prev = 1'b0;
  always @(spi_cs_n or spi_sclk) begin
    if (spi_cs_n !== cs0Prev) begin
      if (!spi_cs_n) begin
        bits0 = 0; cap0 = 48'h0; cmd0 = 8'h0; spi_miso = 1'b0;
      end else if (bits0 == 48 && cmd0 == 8'h02) begin
        mem0[int'(addr0[16:1])] = cap0[15:0];
      end
    end
    if (spi_sclk !== sclk0Prev && !spi_cs_n) begin
      if (spi_sclk) begin
        cap0 = {cap0[46:0], spi_mosi};
        bits0++;
        if (bits0 == 32) begin
          cmd0  = cap0[31:24];
          addr0 = cap0[23:0];
          rdWord0 = mem0.exists(int'(addr0[16:1])) ? mem0[int'(addr0[16:1])] : 16'h0;
        end
      end else if (bits0 >= 32 && bits0 < 48 && cmd0 == 8'h03) begin
        spi_miso = rdWord0[47 - bits0];
      end
    end
    cs0Prev = spi_cs_n;
    sclk0Prev = spi_sclk;
  end

  // Simple read-only SRAM model for the CLK_DIV=1 instance.
  logic [47:0] cap1 = 48'h0;
  logic [15:0] rdWord1 = 16'h5AC3;
  int          bits1 = 0;
  logic        cs1Prev = 1'b1, sclk1Prev = 1'b0;
  always @(cs1 or sclk1) begin
    if (cs1 !== cs1Prev && !cs1) begin
      bits1 = 0; cap1 = 48'h0; miso1 = 1'b0;
    end
    if (sclk1 !== sclk1Prev && !cs1) begin
      if (sclk1) begin
        cap1 = {cap1[46:0], mosi1};
        bits1++;
      end else if (bits1 >= 32 && bits1 < 48) begin
        miso1 = rdWord1[47 - bits1];
      end
    end
    cs1Prev = cs1;
    sclk1Prev = sclk1;
  end

  // Completion monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    if (memory_critical) critCnt++;
    if (memory_ready || write_complete) begin
      if (memory_ready && write_complete) checkOutput("ready_and_done", 48'd1, 48'd0);
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_completion", 48'd1, 48'd0);
      end else begin
        popped = sbQ.pop_front();
        checkOutput("completion_type", 48'(write_complete), 48'(popped.isWrite));
        checkOutput("completion_cycle", 48'(cycleCnt), 48'(popped.dueCycle));
        checkOutput("mosi_frame", cap0, popped.frame);
        checkOutput("cs_n_at_done", 48'(spi_cs_n), 48'd1);
        if (!popped.isWrite) expMemOut = popped.data;
        checkOutput("memory_out", 48'(memory_out), 48'(expMemOut));
      end
    end
  end

  // Drives one request from a negedge and records the expected completion.
  task automatic applyStimulus(input logic isWrite, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] expData);
    txn_t t;
    request = 1'b1;
    request_type = isWrite;
    request_address = addr;
    data_in = wdata;
    t.isWrite = isWrite;
    t.frame = {(isWrite ? 8'h02 : 8'h03), 7'b0, addr, 1'b0, (isWrite ? wdata : 16'h0)};
    t.data = expData;
    t.dueCycle = cycleCnt + 1 + 96 * 2;
    sbQ.push_back(t);
    @(negedge clk);
    request = 1'b0;
    request_type = 1'b0;
    data_in = 16'h0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checkOutput("drain_timeout", 48'd1, 48'd0);
      sbQ.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int critBefore;
    int t0;
    mem0[16'h0012] = 16'hBEEF;
    mem0[16'h8001] = 16'h0000;
    mem0[16'h0100] = 16'h1234;
    repeat (3) @(negedge clk);
    checkOutput("rst_memory_out", 48'(memory_out), 48'h0);
    checkOutput("rst_ready", 48'(memory_ready), 48'h0);
    checkOutput("rst_done", 48'(write_complete), 48'h0);
    checkOutput("rst_crit", 48'(memory_critical), 48'h0);
    checkOutput("rst_cs_n", 48'(spi_cs_n), 48'h1);
    checkOutput("rst_sclk", 48'(spi_sclk), 48'h0);
    checkOutput("rst_mosi", 48'(spi_mosi), 48'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] read word 0x0012");
    applyStimulus(1'b0, 16'h0012, 16'h0000, 16'hBEEF);
    waitDrain(400);
    checkOutput("read_frame_literal", cap0, 48'h03_000024_0000);
    checkOutput("read_out_literal", 48'(memory_out), 48'hBEEF);

    $display("[TB] write 0xA55A to word 0x8001");
    applyStimulus(1'b1, 16'h8001, 16'hA55A, 16'h0000);
    waitDrain(400);
    checkOutput("write_frame_literal", cap0, 48'h02_010002_A55A);
    checkOutput("write_mem_contents", 48'(mem0[16'h8001]), 48'hA55A);
    checkOutput("write_out_unchanged", 48'(memory_out), 48'hBEEF);
    checkOutput("crit_none_yet", 48'(critCnt), 48'd0);

    $display("[TB] overrun during read");
    applyStimulus(1'b0, 16'h0012, 16'h0000, 16'hBEEF);
    repeat (9) @(negedge clk);
    request = 1'b1; request_type = 1'b1; request_address = 16'h0040; data_in = 16'h7777;
    @(negedge clk);
    request = 1'b0; request_type = 1'b0; data_in = 16'h0;
    checkOutput("crit_pulse_high", 48'(memory_critical), 48'd1);
    @(negedge clk);
    checkOutput("crit_pulse_low", 48'(memory_critical), 48'd0);
    waitDrain(400);
    repeat (20) @(negedge clk);
    checkOutput("no_second_frame", 48'(spi_cs_n), 48'd1);
    checkOutput("crit_count", 48'(critCnt), 48'd1);
    checkOutput("dropped_write_absent", 48'(mem0.exists(int'(16'h0040))), 48'd0);

    $display("[TB] reset in the middle of a write");
    applyStimulus(1'b1, 16'h0012, 16'h1111, 16'h0000);
    n = 0;
    while (bits0 < 20 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bit20_reached", 48'(bits0 >= 20), 48'd1);
    reset = 1'b1;
    sbQ.delete();
    expMemOut = 16'h0;
    #1;
    checkOutput("midrst_cs_n", 48'(spi_cs_n), 48'd1);
    checkOutput("midrst_sclk", 48'(spi_sclk), 48'd0);
    checkOutput("midrst_mosi", 48'(spi_mosi), 48'd0);
    checkOutput("midrst_memory_out", 48'(memory_out), 48'd0);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 16'h0012, 16'h0000, 16'hBEEF);
    waitDrain(400);

    $display("[TB] request in the memory_ready cycle");
    critBefore = critCnt;
    applyStimulus(1'b0, 16'h0012, 16'h0000, 16'hBEEF);
    n = 0;
    while (!memory_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_seen", 48'(memory_ready), 48'd1);
    checkOutput("cs_high_in_gap", 48'(spi_cs_n), 48'd1);
    applyStimulus(1'b0, 16'h0100, 16'h0000, 16'h1234);
    checkOutput("cs_low_after_gap", 48'(spi_cs_n), 48'd0);
    waitDrain(400);
    checkOutput("b2b_no_crit", 48'(critCnt), 48'(critBefore));
    checkOutput("b2b_second_data", 48'(memory_out), 48'h1234);

    $display("[TB] CLK_DIV=1 read");
    @(negedge clk);
    req1 = 1'b1;
    addr1 = 16'h0005;
    t0 = cycleCnt + 1;
    @(negedge clk);
    req1 = 1'b0;
    checkOutput("fast_sclk_0", 48'(sclk1), 48'd0);
    @(negedge clk);
    checkOutput("fast_sclk_1", 48'(sclk1), 48'd1);
    @(negedge clk);
    checkOutput("fast_sclk_2", 48'(sclk1), 48'd0);
    @(negedge clk);
    checkOutput("fast_sclk_3", 48'(sclk1), 48'd1);
    n = 0;
    while (!rdy1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fast_ready_seen", 48'(rdy1), 48'd1);
    checkOutput("fast_ready_cycle", 48'(cycleCnt), 48'(t0 + 96));
    checkOutput("fast_data", 48'(out1), 48'h5AC3);
    checkOutput("fast_frame", cap1, 48'h03_00000A_0000);
    checkOutput("fast_no_done", 48'(done1), 48'd0);
    @(negedge clk);
    checkOutput("fast_ready_one_cycle", 48'(rdy1), 48'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
